// File: rtl/mpram_pkg.sv
// Shared widths and write-request types for the LVT multiport RAM and its request scheduler.
package mpram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } wr_req_t;

  typedef addr_t [1:0] addr2_t;
  typedef data_t [1:0] data2_t;

endpackage

// File: rtl/mpram_wr_fifo.sv
// Synchronous write-request FIFO; pointers carry one extra wrap bit so full and empty are distinct.
module mpram_wr_fifo
  import mpram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wr_req_t push_req,
  input  logic    pop,
  output wr_req_t head,
  output logic    valid,
  output logic    full
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr_r;
  logic [PW:0] rd_ptr_r;
  logic        push_en_s;
  logic        pop_en_s;
  wr_req_t     mem_r [DEPTH];

  assign push_en_s = push && !full;
  assign pop_en_s  = pop && valid;

  assign valid = (wr_ptr_r != rd_ptr_r);
  assign full  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                 (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign head  = mem_r[rd_ptr_r[PW-1:0]];

  // Pointer state; reset discards everything queued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_en_s) wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
      if (pop_en_s)  rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push_en_s) mem_r[wr_ptr_r[PW-1:0]] <= push_req;
  end

endmodule

// File: rtl/mpram_req_sched.sv
// Write-request scheduler in front of the 2W/2R LVT RAM: serializes same-address writes
// with alternating priority and forwards same-cycle write data to read responses.
module mpram_req_sched #(
  parameter int DATA_WIDTH = mpram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mpram_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  wr_valid,
  output logic [1:0]                  wr_ready,
  input  logic [1:0][ADDR_WIDTH-1:0]  wr_addr,
  input  logic [1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic [1:0]                  rd_valid_in,
  input  logic [1:0][ADDR_WIDTH-1:0]  rd_addr_in,
  output logic [1:0]                  rd_valid_out,
  output logic [1:0][DATA_WIDTH-1:0]  rd_data_out,
  output logic                        wr_idle,
  output logic [1:0]                  mem_wren,
  output logic [1:0][ADDR_WIDTH-1:0]  mem_wrAddr,
  output logic [1:0][DATA_WIDTH-1:0]  mem_dIn,
  output logic [1:0][ADDR_WIDTH-1:0]  mem_rdAddr,
  input  logic [1:0][DATA_WIDTH-1:0]  mem_dOut
);

  // Widths must agree with mpram_pkg, whose request struct the FIFOs carry
  mpram_pkg::wr_req_t             push_req_s [2];
  mpram_pkg::wr_req_t             head_s     [2];
  logic [1:0]                     head_valid_s;
  logic [1:0]                     full_s;
  logic [1:0]                     push_s;
  logic [1:0]                     pop_s;
  logic                           conflict_s;
  logic                           prio_r;
  logic [1:0]                     fwd_hit_s;
  logic [1:0][DATA_WIDTH-1:0]     fwd_data_s;
  logic [1:0]                     rd_valid_r;
  logic [1:0]                     fwd_hit_r;
  logic [1:0][DATA_WIDTH-1:0]     fwd_data_r;

  assign wr_ready = ~full_s;
  assign push_s   = wr_valid & ~full_s;
  assign wr_idle  = (head_valid_s == 2'b00);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    assign push_req_s[gi] = '{addr: wr_addr[gi], data: wr_data[gi]};

    mpram_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_s[gi]),
      .push_req (push_req_s[gi]),
      .pop      (pop_s[gi]),
      .head     (head_s[gi]),
      .valid    (head_valid_s[gi]),
      .full     (full_s[gi])
    );
  end

  // Arbitration: equal head addresses issue one channel at a time, chosen by prio
  always_comb begin
    conflict_s = 1'b0;
    pop_s      = 2'b00;
    if ((head_valid_s == 2'b11) && (head_s[0].addr == head_s[1].addr)) begin
      conflict_s = 1'b1;
      if (prio_r) begin
        pop_s = 2'b10;
      end else begin
        pop_s = 2'b01;
      end
    end else begin
      pop_s = head_valid_s;
    end
  end

  assign mem_wren   = pop_s;
  assign mem_rdAddr = rd_addr_in;

  // Write-port drive; an unissued port is held at zero
  always_comb begin
    mem_wrAddr = '0;
    mem_dIn    = '0;
    for (int c = 0; c < 2; c++) begin
      if (pop_s[c]) begin
        mem_wrAddr[c] = head_s[c].addr;
        mem_dIn[c]    = head_s[c].data;
      end else begin
        mem_wrAddr[c] = '0;
        mem_dIn[c]    = '0;
      end
    end
  end

  // Forwarding compare; at most one issued write can match a given read address
  always_comb begin
    fwd_hit_s  = 2'b00;
    fwd_data_s = '0;
    for (int p = 0; p < 2; p++) begin
      if (rd_valid_in[p] && pop_s[0] && (rd_addr_in[p] == mem_wrAddr[0])) begin
        fwd_hit_s[p]  = 1'b1;
        fwd_data_s[p] = mem_dIn[0];
      end else if (rd_valid_in[p] && pop_s[1] && (rd_addr_in[p] == mem_wrAddr[1])) begin
        fwd_hit_s[p]  = 1'b1;
        fwd_data_s[p] = mem_dIn[1];
      end else begin
        fwd_hit_s[p]  = 1'b0;
        fwd_data_s[p] = '0;
      end
    end
  end

  // Priority toggle and read-response pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_r     <= 1'b0;
      rd_valid_r <= 2'b00;
      fwd_hit_r  <= 2'b00;
      fwd_data_r <= '0;
    end else begin
      if (conflict_s) prio_r <= ~prio_r;
      rd_valid_r <= rd_valid_in;
      fwd_hit_r  <= fwd_hit_s;
      fwd_data_r <= fwd_data_s;
    end
  end

  assign rd_valid_out = rd_valid_r;

  // Response data: captured write data on a forward hit, otherwise the RAM's registered read
  always_comb begin
    rd_data_out = '0;
    for (int p = 0; p < 2; p++) begin
      if (!rd_valid_r[p]) begin
        rd_data_out[p] = '0;
      end else if (fwd_hit_r[p]) begin
        rd_data_out[p] = fwd_data_r[p];
      end else begin
        rd_data_out[p] = mem_dOut[p];
      end
    end
  end

endmodule

// File: tb/tb_mpram_req_sched.sv
// Scoreboard bench for mpram_req_sched with a behavioural 2W/2R RAM (registered read).
module tb_mpram_req_sched;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [1:0]          wr_valid, wr_ready, rd_valid_in, rd_valid_out, mem_wren;
  logic [1:0][AW-1:0]  wr_addr, rd_addr_in, mem_wrAddr, mem_rdAddr;
  logic [1:0][DW-1:0]  wr_data, rd_data_out, mem_dIn, mem_dOut;
  logic                wr_idle;

  logic [DW-1:0]       ram [32];
  req_t                wq [2][$];
  logic [DW-1:0]       rq [2][$];
  logic                prio_m = 1'b0;
  int                  n_chk = 0;
  int                  n_pass = 0;

  always #5 clk = ~clk;

  mpram_req_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_valid_in  (rd_valid_in),
    .rd_addr_in   (rd_addr_in),
    .rd_valid_out (rd_valid_out),
    .rd_data_out  (rd_data_out),
    .wr_idle      (wr_idle),
    .mem_wren     (mem_wren),
    .mem_wrAddr   (mem_wrAddr),
    .mem_dIn      (mem_dIn),
    .mem_rdAddr   (mem_rdAddr),
    .mem_dOut     (mem_dOut)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural RAM: writes at the edge, read data registered (old value on same-cycle write)
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) if (mem_wren[c] === 1'b1) ram[mem_wrAddr[c]] <= mem_dIn[c];
    for (int p = 0; p < 2; p++) mem_dOut[p] <= ram[mem_rdAddr[p]];
  end

  // Monitor/scoreboard, mid-cycle
  always @(negedge clk) begin : monitor
    logic [1:0]    v, iss, rdy;
    req_t          hd [2];
    logic [DW-1:0] e;
    logic          cf;
    if (!reset) begin
      wq[0].delete(); wq[1].delete(); rq[0].delete(); rq[1].delete();
      prio_m = 1'b0;
      chk("rst_wren", 32'(mem_wren), 32'd0);
      chk("rst_rvalid", 32'(rd_valid_out), 32'd0);
      chk("rst_rdata", 32'(rd_data_out), 32'd0);
      chk("rst_ready", 32'(wr_ready), 32'd3);
      chk("rst_idle", 32'(wr_idle), 32'd1);
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rq[p].size() > 0) begin
          e = rq[p].pop_front();
          chk("rd_valid", 32'(rd_valid_out[p]), 32'd1);
          chk("rd_data", 32'(rd_data_out[p]), 32'(e));
        end else begin
          chk("rd_valid", 32'(rd_valid_out[p]), 32'd0);
        end
      end
      for (int c = 0; c < 2; c++) begin
        v[c]   = (wq[c].size() > 0);
        rdy[c] = (wq[c].size() < DEPTH);
        hd[c]  = v[c] ? wq[c][0] : '0;
      end
      cf  = (v == 2'b11) && (hd[0].addr == hd[1].addr);
      iss = cf ? (prio_m ? 2'b10 : 2'b01) : v;
      chk("wren", 32'(mem_wren), 32'(iss));
      chk("wr_ready", 32'(wr_ready), 32'(rdy));
      chk("wr_idle", 32'(wr_idle), 32'(v == 2'b00));
      for (int c = 0; c < 2; c++) begin
        if (iss[c]) begin
          chk("wr_addr", 32'(mem_wrAddr[c]), 32'(hd[c].addr));
          chk("wr_data", 32'(mem_dIn[c]), 32'(hd[c].data));
          void'(wq[c].pop_front());
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (rd_valid_in[p]) begin
          e = ram[rd_addr_in[p]];
          for (int c = 0; c < 2; c++) if (iss[c] && hd[c].addr == rd_addr_in[p]) e = hd[c].data;
          rq[p].push_back(e);
        end
      end
      for (int c = 0; c < 2; c++)
        if (wr_valid[c] && rdy[c]) wq[c].push_back('{addr: wr_addr[c], data: wr_data[c]});
      if (cf) prio_m = ~prio_m;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_valid = 2'b00; rd_valid_in = 2'b00;
    wr_addr = '0; wr_data = '0; rd_addr_in = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!wr_idle && n < 50) begin
      step();
      n++;
    end
    chk("idle_wait", 32'(wr_idle), 32'd1);
  endtask

  task automatic write2(input logic [1:0] vld, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    wr_valid = vld; wr_addr[0] = a0; wr_data[0] = d0; wr_addr[1] = a1; wr_data[1] = d1;
    step();
    wr_valid = 2'b00;
  endtask

  task automatic read1(input int p, input logic [AW-1:0] a);
    rd_valid_in[p] = 1'b1; rd_addr_in[p] = a;
    step();
    rd_valid_in = 2'b00;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic saw_full;
    for (int i = 0; i < 32; i++) ram[i] = 8'h00;
    mem_dOut = '0;
    clear_inputs();
    repeat (3) step();
    reset = 1'b1;
    step();

    // Single ch0 write, then read it back after the queue drains
    write2(2'b01, 5'd3, 8'hA5, 5'd0, 8'h00);
    chk("t1_issue", 32'(mem_wren), 32'd1);
    wait_idle();
    read1(0, 5'd3);
    chk("t1_read", 32'(rd_data_out[0]), 32'hA5);

    // Different addresses issue together
    write2(2'b11, 5'd5, 8'h11, 5'd9, 8'h22);
    chk("t2_dual", 32'(mem_wren), 32'd3);
    step();
    chk("t2_idle", 32'(wr_idle), 32'd1);

    // Same-address conflict, prio 0: ch0 first, ch1 last wins
    write2(2'b11, 5'd7, 8'h01, 5'd7, 8'h02);
    chk("t3_first", 32'(mem_wren), 32'd1);
    step();
    chk("t3_second", 32'(mem_wren), 32'd2);
    wait_idle();
    read1(1, 5'd7);
    chk("t3_read", 32'(rd_data_out[1]), 32'h02);

    // Conflict again: prio toggled, ch1 first, ch0 last wins
    write2(2'b11, 5'd7, 8'h03, 5'd7, 8'h04);
    chk("t3b_first", 32'(mem_wren), 32'd2);
    step();
    chk("t3b_second", 32'(mem_wren), 32'd1);
    wait_idle();
    read1(1, 5'd7);
    chk("t3b_read", 32'(rd_data_out[1]), 32'h03);

    // Read in the same cycle the write issues gets forwarded data
    write2(2'b01, 5'd12, 8'h5A, 5'd0, 8'h00);
    read1(1, 5'd12);
    chk("t4_fwd", 32'(rd_data_out[1]), 32'h5A);

    // Sustained same-address pressure fills ch1
    saw_full = 1'b0;
    wr_valid = 2'b11; wr_addr[0] = 5'd20; wr_addr[1] = 5'd20;
    for (int i = 0; i < 12; i++) begin
      wr_data[0] = 8'(i); wr_data[1] = 8'(8'h80 + i);
      step();
      if (wr_ready[1] == 1'b0) saw_full = 1'b1;
    end
    clear_inputs();
    chk("t5_full_seen", 32'(saw_full), 32'd1);
    wait_idle();

    // Random traffic over a small address range to provoke conflicts and forwarding
    for (int i = 0; i < 300; i++) begin
      wr_valid = 2'($urandom_range(0, 3));
      rd_valid_in = 2'($urandom_range(0, 3));
      for (int c = 0; c < 2; c++) begin
        wr_addr[c] = 5'($urandom_range(0, 7));
        wr_data[c] = 8'($urandom_range(0, 255));
        rd_addr_in[c] = 5'($urandom_range(0, 7));
      end
      step();
    end
    clear_inputs();
    wait_idle();
    step();

    // Reset with three writes queued: everything is discarded
    write2(2'b11, 5'd25, 8'h31, 5'd25, 8'h32);
    write2(2'b11, 5'd25, 8'h33, 5'd25, 8'h34);
    reset = 1'b0;
    #1;
    chk("t6_idle", 32'(wr_idle), 32'd1);
    chk("t6_wren", 32'(mem_wren), 32'd0);
    chk("t6_ready", 32'(wr_ready), 32'd3);
    step();
    step();
    reset = 1'b1;
    repeat (6) step();
    chk("t6_stay_idle", 32'(wr_idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mpram_req_sched.md
# mpram_req_sched

Request scheduler sitting directly upstream of the 2-write/2-read LVT multiport RAM. It buffers two independent write request streams and resolves same-address write collisions, which the LVT cannot arbitrate, by serializing them with fair priority. It drives the RAM's write ports and passes the two read ports through. It also forwards same-cycle write data to read responses, so reads never observe stale data for a write issued in the same cycle.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must match the RAM.
- ADDR_WIDTH, 5, address width; must match the RAM.
- FIFO_DEPTH, 4, entries per write-channel FIFO; power of two, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- wr_valid  in  [1:0]  write request valid per channel.
- wr_ready  out  [1:0]  channel FIFO not full.
- wr_addr  in  [1:0][ADDR_WIDTH-1:0]  write address per channel.
- wr_data  in  [1:0][DATA_WIDTH-1:0]  write data per channel.
- rd_valid_in  in  [1:0]  read request valid; no backpressure.
- rd_addr_in  in  [1:0][ADDR_WIDTH-1:0]  read address.
- rd_valid_out  out  [1:0]  read response valid.
- rd_data_out  out  [1:0][DATA_WIDTH-1:0]  read response data.
- wr_idle  out  1  both FIFOs empty.
- mem_wren  out  [1:0]  to RAM wren.
- mem_wrAddr  out  [1:0][ADDR_WIDTH-1:0]  to RAM wrAddr.
- mem_dIn  out  [1:0][DATA_WIDTH-1:0]  to RAM dIn.
- mem_rdAddr  out  [1:0][ADDR_WIDTH-1:0]  to RAM rdAddr.
- mem_dOut  in  [1:0][DATA_WIDTH-1:0]  from RAM dOut.

## Operation
- Write accept: channel c is pushed when wr_valid[c] && wr_ready[c]. wr_ready[c] = !full[c], registered FIFO state only.
- Issue, each cycle, from the FIFO heads h0/h1:
  - Only one head valid: issue it on its own port.
  - Both valid, addresses differ: issue both. mem_wren = 2'b11. Pop both.
  - Both valid, addresses equal (conflict): issue only the channel selected by prio (0 → ch0, 1 → ch1) and pop it. The other head stays. Toggle prio.
- Issue ports: ch0 always issues on port 0, ch1 on port 1. An unissued port has mem_wren bit = 0, and its addr/data are don't-care (drive 0).
- Ordering: within a channel, writes issue in acceptance order. Across channels, the only ordering guarantee is the conflict rule above.
- Reads: mem_rdAddr = rd_addr_in, combinational pass-through.
- Forwarding: if a read's address matches an issued write's address in the same cycle, the response returns that write's data (captured in a register), not mem_dOut. At most one issued write can match, because same-address writes never issue together.
- Reads are not ordered against writes still queued in the FIFOs. The upstream block waits for wr_idle before any read needing those writes.

## Timing
- Reset values: FIFOs empty, prio = 0, mem_wren = 0, rd_valid_out = 0, rd_data_out = 0, wr_ready = 2'b11, wr_idle = 1.
- Write acceptance latency: accept at edge t → earliest issue (mem_wren high) in cycle t+1.
- Issue outputs are combinational from the FIFO heads and prio.
- Read latency: request in cycle t → rd_valid_out/rd_data_out in cycle t+1, for exactly one cycle per request.
- Full FIFO: wr_ready low. A push and pop in the same cycle on a full FIFO is not permitted, since ready is already low.
- Empty FIFO: no issue on that port.
- Wrap-around: FIFO pointers carry ADDR log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty.
- Reset mid-operation: queued writes are discarded, in-flight read responses are dropped, and prio returns to 0.

## Structure
- Package mpram_pkg holds:
  - localparams DATA_WIDTH and ADDR_WIDTH, shared with the RAM and LVT.
  - typedef wr_req_t {addr, data}.
  - typedef for the 2-port address and data arrays.
- Sub-module mpram_wr_fifo: synchronous FIFO of wr_req_t with depth FIFO_DEPTH, exposing head, valid, full and pop. It is instantiated once per channel.
- Arbitration, forwarding compare and response registers stay in the top module.

## Test plan
- Reset, then a ch0 write (addr 3, data 0xA5) → mem_wren = 2'b01 one cycle later; a read of addr 3 after wr_idle returns 0xA5.
- Both channels write different addresses (5 → 0x11, 9 → 0x22) in the same cycle → a single issue cycle with mem_wren = 2'b11.
- Both channels write addr 7 (0x01 on ch0, 0x02 on ch1) with prio = 0 → ch0 issues in cycle t+1 and ch1 in t+2; addr 7 reads 0x02. Repeat with 0x03 on ch0 and 0x04 on ch1 → ch1 issues first (prio toggled) and addr 7 ends as 0x03.
- A ch0 write to addr 12 (0x5A) issues in the same cycle as a port-1 read of addr 12 → rd_data_out[1] = 0x5A in the next cycle.
- ch1 is pushed FIFO_DEPTH times while its head conflicts → wr_ready[1] drops after the 4th push and rises after the first pop.
- Assert reset with 3 writes queued → wr_idle = 1 and mem_wren = 0 immediately, and no queued write ever issues.
